// File: rtl/hzu_sb.sv
// hzu_sb: scoreboarded hazard unit for the 5-stage in-order core.
//
// Combines the classic MEM/WB forwarding, load-use, load-store and
// branch-flush rules with a per-register pending scoreboard for
// variable-latency ops (divider, wait-stated memory). These ops leave the
// pipeline at EX and write back out of band.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   *_id                 ID stage sources/destination, store and long-latency flags
//   *_ex                 EX stage sources/destination, load flag, long-latency issue,
//                        taken branch
//   *_mem, *_wb          MEM/WB destinations, write enables, load/store flags
//   lat_done/lat_rd_addr long-latency writeback port
//   forward_*_sel        operand forward selects (00 rf, 01 MEM, 10 WB)
//   forward_store_sel    store-data forward select (00 normal, 01 WB)
//   stall/flush_*        pipeline control
//   busy_regs            scoreboard bits, bit 0 always 0
//   pending_cnt          outstanding long-latency ops
//   sb_err               sticky protocol error
//   stall_cycles         saturating count of stalled cycles
//
// Handshake: there is no valid/ready pair here. lat_issue_ex and lat_done
// are single-cycle strobes that are sampled at every rising clk edge. The
// long-latency unit must never report lat_done for a register it was not
// issued.
module hzu_sb #(
  parameter int NUM_REGS    = 32,
  parameter int AW          = 5,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [AW-1:0]                    rs1_addr_id,
  input  logic [AW-1:0]                    rs2_addr_id,
  input  logic [AW-1:0]                    rd_addr_id,
  input  logic                             is_store_id,
  input  logic                             is_lat_id,
  input  logic [AW-1:0]                    rs1_addr_ex,
  input  logic [AW-1:0]                    rs2_addr_ex,
  input  logic [AW-1:0]                    rd_addr_ex,
  input  logic                             rd_we_ex,
  input  logic                             is_load_ex,
  input  logic                             lat_issue_ex,
  input  logic                             tk_brnch_ex,
  input  logic [AW-1:0]                    rs2_addr_mem,
  input  logic [AW-1:0]                    rd_addr_mem,
  input  logic                             rd_we_mem,
  input  logic                             is_load_mem,
  input  logic                             is_store_mem,
  input  logic [AW-1:0]                    rd_addr_wb,
  input  logic                             rd_we_wb,
  input  logic                             lat_done,
  input  logic [AW-1:0]                    lat_rd_addr,
  output logic [1:0]                       forward_a_sel,
  output logic [1:0]                       forward_b_sel,
  output logic [1:0]                       forward_store_sel,
  output logic                             stall,
  output logic                             flush_if_id,
  output logic                             flush_id_ex,
  output logic [NUM_REGS-1:0]              busy_regs,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending_cnt,
  output logic                             sb_err,
  output logic [CNT_W-1:0]                 stall_cycles
);

  localparam int PW = $clog2(MAX_PENDING+1);
  localparam logic [PW-1:0] MAX_PW = PW'(MAX_PENDING);
  localparam logic [PW:0]   MAX_P1 = (PW+1)'(MAX_PENDING);

  // A register is trackable when it is not x0 and lies inside the file.
  function automatic logic trackable(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  // Scoreboard lookup that tolerates addresses beyond NUM_REGS.
  function automatic logic busy_at(input logic [NUM_REGS-1:0] v,
                                   input logic [AW-1:0] a);
    logic r;
    r = 1'b0;
    for (int i = 1; i < NUM_REGS; i++)
      if (a == AW'(i)) r = v[i];
    return r;
  endfunction

  // ---------------- forwarding ----------------
  logic mem_fwd_ok, wb_fwd_ok;
  assign mem_fwd_ok = rd_we_mem && !is_load_mem && (rd_addr_mem != '0);
  assign wb_fwd_ok  = rd_we_wb && (rd_addr_wb != '0);

  always_comb begin
    forward_a_sel     = 2'b00;
    forward_b_sel     = 2'b00;
    forward_store_sel = 2'b00;
    if (mem_fwd_ok && rd_addr_mem == rs1_addr_ex)     forward_a_sel = 2'b01;
    else if (wb_fwd_ok && rd_addr_wb == rs1_addr_ex)  forward_a_sel = 2'b10;
    if (mem_fwd_ok && rd_addr_mem == rs2_addr_ex)     forward_b_sel = 2'b01;
    else if (wb_fwd_ok && rd_addr_wb == rs2_addr_ex)  forward_b_sel = 2'b10;
    if (is_store_mem && wb_fwd_ok && rd_addr_wb == rs2_addr_mem)
      forward_store_sel = 2'b01;
  end

  // ---------------- stall sources ----------------
  logic load_use_rs1, load_use_rs2, store_hz;
  logic raw_rs1, raw_rs2, waw_hz, issue_hz, cap_hz, any_stall;
  logic [PW:0] cap_sum;

  assign load_use_rs1 = is_load_ex && (rd_addr_ex != '0) && (rd_addr_ex == rs1_addr_id);
  assign load_use_rs2 = is_load_ex && !is_store_id && (rd_addr_ex != '0) &&
                        (rd_addr_ex == rs2_addr_id);
  assign store_hz = is_store_id && (rs2_addr_id != '0) &&
                    ((is_load_ex  && rd_addr_ex  == rs2_addr_id) ||
                     (is_load_mem && rd_addr_mem == rs2_addr_id) ||
                     (rd_we_wb    && rd_addr_wb  == rs2_addr_id));

  // A source whose producer is writing back this very cycle reads the
  // write-through regfile, so it is released without a forward path.
  assign raw_rs1 = busy_at(busy_regs, rs1_addr_id) &&
                   !(lat_done && lat_rd_addr == rs1_addr_id);
  assign raw_rs2 = busy_at(busy_regs, rs2_addr_id) &&
                   !(lat_done && lat_rd_addr == rs2_addr_id);
  assign waw_hz  = is_lat_id && busy_at(busy_regs, rd_addr_id);
  // The op leaving EX is not yet in the scoreboard, so match it directly.
  assign issue_hz = lat_issue_ex && (rd_addr_ex != '0) &&
                    ((rd_addr_ex == rs1_addr_id) || (rd_addr_ex == rs2_addr_id));
  assign cap_sum = {1'b0, pending_cnt} + {{PW{1'b0}}, lat_issue_ex};
  assign cap_hz  = is_lat_id && (cap_sum >= MAX_P1);

  assign any_stall = load_use_rs1 || load_use_rs2 || store_hz ||
                     raw_rs1 || raw_rs2 || waw_hz || issue_hz || cap_hz;

  // A taken branch squashes the ID instruction, so its hazards are moot.
  assign stall       = any_stall && !tk_brnch_ex;
  assign flush_if_id = tk_brnch_ex;
  assign flush_id_ex = tk_brnch_ex || stall;

  // ---------------- scoreboard update ----------------
  logic issue_v, done_v, done_ok, issue_ok, same_reg, issue_busy_err, full_err;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [PW-1:0]       cnt_nxt;
  logic                err_nxt;

  assign issue_v  = lat_issue_ex && trackable(rd_addr_ex);
  assign done_v   = lat_done && trackable(lat_rd_addr);
  assign done_ok  = done_v && busy_at(busy_regs, lat_rd_addr);
  assign same_reg = done_ok && (lat_rd_addr == rd_addr_ex);
  // Re-issuing to a register that retires this same cycle is legal.
  assign issue_busy_err = issue_v && busy_at(busy_regs, rd_addr_ex) && !same_reg;
  // A slot retiring this cycle can be reused by the issue in the same cycle.
  assign full_err = issue_v && (pending_cnt == MAX_PW) && !done_ok;
  assign issue_ok = issue_v && !issue_busy_err && !full_err;

  always_comb begin
    busy_nxt = busy_regs;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (done_ok  && lat_rd_addr == AW'(i)) busy_nxt[i] = 1'b0;
      if (issue_ok && rd_addr_ex  == AW'(i)) busy_nxt[i] = 1'b1;  // set wins
    end
    busy_nxt[0] = 1'b0;
    cnt_nxt = pending_cnt;
    if (issue_ok && !done_ok)      cnt_nxt = pending_cnt + 1'b1;
    else if (!issue_ok && done_ok) cnt_nxt = pending_cnt - 1'b1;
    err_nxt = sb_err || (done_v && !done_ok) || issue_busy_err || full_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_regs    <= '0;
      pending_cnt  <= '0;
      sb_err       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      busy_regs   <= busy_nxt;
      pending_cnt <= cnt_nxt;
      sb_err      <= err_nxt;
      if (stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  // Operand sources in EX feed only the forward selects; EX rd_we is
  // implied for loads and long-latency ops and is kept for interface parity.
  logic unused_ok;
  assign unused_ok = rd_we_ex;

endmodule

// File: doc/hzu_sb.md
Name: hzu_sb

Overview:
- Scoreboarded hazard unit for the 5-stage in-order core. It is the successor of the fixed forwarding/stall unit.
- Keeps the MEM/WB forwarding, load-use, load-store and branch-flush rules, and adds a per-register pending scoreboard for variable-latency ops (div, wait-stated memory) that complete out of band.
- Also adds a capacity limit on outstanding long-latency ops, a sticky scoreboard-error flag and a stall-cycle counter.
- Sits beside the pipeline registers and drives the stall, flush and forward selects.

Parameters:
NUM_REGS, 32, architectural register count; x0 is never tracked.
AW, 5, register address width; must satisfy 2**AW >= NUM_REGS.
MAX_PENDING, 4, maximum outstanding long-latency ops, 1..NUM_REGS-1.
CNT_W, 16, stall-cycle counter width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rs1_addr_id  in  AW  ID source 1
rs2_addr_id  in  AW  ID source 2
rd_addr_id  in  AW  ID destination
is_store_id  in  1  ID holds a store
is_lat_id  in  1  ID holds a long-latency op
rs1_addr_ex  in  AW  EX source 1
rs2_addr_ex  in  AW  EX source 2
rd_addr_ex  in  AW  EX destination
rd_we_ex  in  1  EX writes rd
is_load_ex  in  1  EX holds a load
lat_issue_ex  in  1  EX op leaves the pipeline to a long-latency unit this cycle
tk_brnch_ex  in  1  taken branch/jump in EX
rs2_addr_mem  in  AW  MEM store-data source
rd_addr_mem  in  AW  MEM destination
rd_we_mem  in  1  MEM writes rd
is_load_mem  in  1  MEM holds a load
is_store_mem  in  1  MEM holds a store
rd_addr_wb  in  AW  WB destination
rd_we_wb  in  1  WB writes rd
lat_done  in  1  long-latency unit writes back this cycle
lat_rd_addr  in  AW  long-latency writeback destination
forward_a_sel  out  2  00 regfile, 01 MEM, 10 WB
forward_b_sel  out  2  same encoding
forward_store_sel  out  2  00 normal, 01 WB
stall  out  1  hold PC and IF/ID
flush_if_id  out  1  clear IF/ID
flush_id_ex  out  1  insert bubble into ID/EX
busy_regs  out  NUM_REGS  scoreboard bits
pending_cnt  out  $clog2(MAX_PENDING+1)  outstanding long-latency ops
sb_err  out  1  sticky protocol error
stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset: busy_regs=0, pending_cnt=0, sb_err=0, stall_cycles=0. The combinational outputs follow their inputs.
- Forwarding and match rules are unchanged from the current unit:
  - MEM beats WB; no MEM forward when is_load_mem; x0 never matches.
  - Store in MEM with rs2 matching WB -> forward_store_sel=01.
- Legacy stall sources, unchanged:
  - load-use on rs1;
  - load-use on rs2 unless is_store_id;
  - store in ID with rs2 matching a load in EX or in MEM, or any rd_we_wb in WB.
- Scoreboard stall sources:
  - busy_regs[rs1_addr_id] or busy_regs[rs2_addr_id] set (RAW);
  - is_lat_id and busy_regs[rd_addr_id] set (WAW);
  - lat_issue_ex and rd_addr_ex matching an ID rs (hazard against the op just leaving the pipe);
  - is_lat_id and (pending_cnt + lat_issue_ex) >= MAX_PENDING (capacity).
- Completion bypass: if lat_done and lat_rd_addr equals a busy ID source, that source does not stall this cycle. The regfile is write-through, so no extra forward select is needed.
- Branch priority:
  - stall = any stall source && !tk_brnch_ex.
  - flush_if_id = tk_brnch_ex.
  - flush_id_ex = tk_brnch_ex || stall.
- Scoreboard update at the clk edge, x0 ignored:
  - lat_issue_ex sets busy[rd_addr_ex];
  - a valid lat_done clears busy[lat_rd_addr];
  - set and clear on the same register in one cycle -> bit stays 1 and pending_cnt is unchanged.
- pending_cnt: +1 on a valid issue, -1 on a valid done, unchanged when both occur.
- Errors: each of the following sets sb_err, sticky until rst:
  - lat_done to a clear register (ignored, no decrement);
  - lat_issue_ex to an already-busy register (bit stays 1, no increment);
  - issue with pending_cnt==MAX_PENDING (dropped).
- stall_cycles: +1 on each cycle with stall=1, saturating at all-ones.
- rst mid-operation clears every outstanding entry. The long-latency units are reset by the same rst.

Test Plan:
- Reset, then idle 5 cycles -> busy_regs=0, pending_cnt=0, stall=0, forward selects 00, stall_cycles=0.
- Issue div to x5 (lat_issue_ex, rd_addr_ex=5). Next cycle ID reads rs1=x5 -> stall=1 and flush_id_ex=1 until lat_done with x5. On the done cycle stall=0, busy_regs[5] clears at the next edge, and stall_cycles equals the number of stalled cycles.
- MAX_PENDING=4: issue to x1..x4. ID is_lat_id with rd=x6 -> stall=1. A lat_done for x2 -> stall drops the next cycle and pending_cnt goes 4->3.
- Same cycle lat_done x7 and lat_issue_ex x7 (x7 busy) -> busy_regs[7]=1, pending_cnt unchanged, sb_err=0. Then lat_done x9 with x9 clear -> sb_err=1 and it holds until rst.
- Load x3 in EX with ID add rs1=x3 while tk_brnch_ex=1 -> stall=0, flush_if_id=1, flush_id_ex=1.
- ALU writes x8 in MEM, EX reads rs1=x8 and rs2=x8, WB also writes x8 -> forward_a_sel=01 and forward_b_sel=01. Repeat with is_load_mem=1 -> both selects 10.
